// File: rtl/int_to_recfn_arbiter.sv
// Round-robin front end that shares one INToRecFN converter between NREQ requesters.
// S1 registers the selected operand for the converter, S2 registers the converter result.
module int_to_recfn_arbiter #(
   parameter int NREQ  = 2,
   parameter int TAG_W = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [2:0]                frm,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ-1:0]           req_signed,
   input  logic [NREQ*64-1:0]        req_data,
   input  logic [NREQ*3-1:0]         req_rm,
   input  logic [NREQ*TAG_W-1:0]     req_tag,
   output logic                      conv_signedIn,
   output logic [63:0]               conv_in,
   output logic [2:0]                conv_roundingMode,
   input  logic [64:0]               conv_out,
   input  logic [4:0]                conv_exc,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [64:0]               resp_data,
   output logic [4:0]                resp_exc,
   output logic [TAG_W-1:0]          resp_tag,
   output logic [$clog2(NREQ)-1:0]   resp_src
);

   localparam int SRC_W = $clog2(NREQ);
   localparam int unsigned NREQ_U = NREQ;

   logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0] grant;
   logic             found;
   int unsigned      idx;
   int unsigned      g;

   logic             s1_v_q, s1_v_d;
   logic             s1_signed_q, s1_signed_d;
   logic [63:0]      s1_data_q, s1_data_d;
   logic [2:0]       s1_rm_q, s1_rm_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   logic [SRC_W-1:0] s1_src_q, s1_src_d;

   logic             s2_v_q, s2_v_d;
   logic [64:0]      s2_data_q, s2_data_d;
   logic [4:0]       s2_exc_q, s2_exc_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
   logic [SRC_W-1:0] s2_src_q, s2_src_d;

   logic             s2_adv, s1_free, accept, resp_fire;
   logic [2:0]       sel_rm;

   assign s2_adv    = s1_v_q & (~s2_v_q | resp_ready);
   assign s1_free   = ~s1_v_q | s2_adv;
   assign resp_fire = s2_v_q & resp_ready;

   // With no request pending the grant rests on rr_ptr, so req_ready still
   // reflects pipeline space without depending on any req_valid bit.
   always_comb begin
      grant = rr_ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = NREQ_U; k > 0; k--) begin
         idx = (32'(rr_ptr_q) + k - 1) % NREQ_U;
         if (req_valid[idx]) begin
            grant = SRC_W'(idx);
            found = 1'b1;
         end
      end
      g         = 32'(grant);
      req_ready = '0;
      req_ready[grant] = s1_free & ~flush & reset;
      accept    = found & req_valid[grant] & req_ready[grant];
   end

   always_comb begin
      sel_rm   = req_rm[g*3 +: 3];
      rr_ptr_d = accept ? SRC_W'((g + 1) % NREQ_U) : rr_ptr_q;

      s1_v_d      = s1_v_q;
      s1_signed_d = s1_signed_q;
      s1_data_d   = s1_data_q;
      s1_rm_d     = s1_rm_q;
      s1_tag_d    = s1_tag_q;
      s1_src_d    = s1_src_q;
      if (accept) begin
         s1_v_d      = 1'b1;
         s1_signed_d = req_signed[grant];
         s1_data_d   = req_data[g*64 +: 64];
         s1_rm_d     = (sel_rm == 3'b111) ? frm : sel_rm;
         s1_tag_d    = req_tag[g*TAG_W +: TAG_W];
         s1_src_d    = grant;
      end else if (s2_adv) begin
         s1_v_d = 1'b0;
      end

      s2_v_d    = s2_v_q;
      s2_data_d = s2_data_q;
      s2_exc_d  = s2_exc_q;
      s2_tag_d  = s2_tag_q;
      s2_src_d  = s2_src_q;
      if (s2_adv) begin
         s2_v_d    = 1'b1;
         s2_data_d = conv_out;
         s2_exc_d  = conv_exc;
         s2_tag_d  = s1_tag_q;
         s2_src_d  = s1_src_q;
      end else if (resp_fire) begin
         s2_v_d = 1'b0;
      end

      if (flush) begin
         s1_v_d = 1'b0;
         s2_v_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rr_ptr_q    <= '0;
         s1_v_q      <= 1'b0;
         s1_signed_q <= 1'b0;
         s1_data_q   <= '0;
         s1_rm_q     <= '0;
         s1_tag_q    <= '0;
         s1_src_q    <= '0;
         s2_v_q      <= 1'b0;
         s2_data_q   <= '0;
         s2_exc_q    <= '0;
         s2_tag_q    <= '0;
         s2_src_q    <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         s1_v_q      <= s1_v_d;
         s1_signed_q <= s1_signed_d;
         s1_data_q   <= s1_data_d;
         s1_rm_q     <= s1_rm_d;
         s1_tag_q    <= s1_tag_d;
         s1_src_q    <= s1_src_d;
         s2_v_q      <= s2_v_d;
         s2_data_q   <= s2_data_d;
         s2_exc_q    <= s2_exc_d;
         s2_tag_q    <= s2_tag_d;
         s2_src_q    <= s2_src_d;
      end
   end

   assign conv_signedIn     = s1_signed_q;
   assign conv_in           = s1_data_q;
   assign conv_roundingMode = s1_rm_q;

   assign resp_valid = s2_v_q;
   assign resp_data  = s2_data_q;
   assign resp_exc   = s2_exc_q;
   assign resp_tag   = s2_tag_q;
   assign resp_src   = s2_src_q;

endmodule

// File: tb/tb_int_to_recfn_arbiter.sv
// Scoreboard bench for int_to_recfn_arbiter with a behavioural int->recoded-double converter
// beside the DUT; directed scenarios followed by randomized traffic, flushes and resets.
module tb_int_to_recfn_arbiter;
   localparam int NREQ  = 2;
   localparam int TAG_W = 8;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic                  flush = 1'b0;
   logic [2:0]            frm = '0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       req_signed = '0;
   logic [NREQ*64-1:0]    req_data = '0;
   logic [NREQ*3-1:0]     req_rm = '0;
   logic [NREQ*TAG_W-1:0] req_tag = '0;
   logic                  conv_signedIn;
   logic [63:0]           conv_in;
   logic [2:0]            conv_roundingMode;
   logic [64:0]           conv_out;
   logic [4:0]            conv_exc;
   logic                  resp_valid;
   logic                  resp_ready = 1'b0;
   logic [64:0]           resp_data;
   logic [4:0]            resp_exc;
   logic [TAG_W-1:0]      resp_tag;
   logic                  resp_src;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [64:0]      data;
      logic [4:0]       exc;
      logic [TAG_W-1:0] tag;
      logic             src;
      int               acc;
   } exp_t;

   exp_t q[$];
   int   acc_log[$];
   int   mdl_ptr = 0;
   logic hold_prev = 1'b0;
   logic [78:0] hold_val = '0;
   logic [TAG_W-1:0] tagc = '0;

   int_to_recfn_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset), .flush(flush), .frm(frm),
      .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
      .req_data(req_data), .req_rm(req_rm), .req_tag(req_tag),
      .conv_signedIn(conv_signedIn), .conv_in(conv_in),
      .conv_roundingMode(conv_roundingMode), .conv_out(conv_out), .conv_exc(conv_exc),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_exc(resp_exc), .resp_tag(resp_tag), .resp_src(resp_src)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Integer -> recoded double; the stub echoes the rounding mode in the NV/DZ/OF
   // flag positions (never raised by this conversion) so the mode reaching it is visible.
   function automatic logic [69:0] conv_ref(input logic s, input logic [63:0] x, input logic [2:0] rm);
      logic neg, nx, up;
      logic [63:0] mag, rem, half;
      logic [64:0] sig;
      int p;
      neg = s & x[63];
      mag = neg ? (~x + 64'd1) : x;
      nx = 1'b0;
      up = 1'b0;
      if (mag == 64'd0) return {rm, 2'b00, 65'd0};
      p = 0;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      if (p <= 52) begin
         sig = 65'(mag) << (52 - p);
      end else begin
         sig  = 65'(mag >> (p - 52));
         rem  = mag & ((64'd1 << (p - 52)) - 64'd1);
         half = 64'd1 << (p - 53);
         nx   = (rem != 64'd0);
         case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = neg & nx;
            3'd3:    up = ~neg & nx;
            3'd4:    up = (rem >= half);
            default: up = (rem > half) || ((rem == half) && sig[0]);
         endcase
         if (up) sig = sig + 65'd1;
         if (sig[53]) begin
            sig = sig >> 1;
            p = p + 1;
         end
      end
      p = p + 2048;
      return {rm, 1'b0, nx, neg, p[11:0], sig[51:0]};
   endfunction

   always_comb {conv_exc, conv_out} = conv_ref(conv_signedIn, conv_in, conv_roundingMode);

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor/scoreboard: accepts push expectations, handshakes pop and compare.
   always @(negedge clock) begin
      logic [NREQ-1:0] exp_ready;
      logic [2:0]      rm_eff;
      logic [69:0]     r;
      logic            free, exp_rv;
      int              gi;
      exp_t            e;
      if (!reset) begin
         chk("reset_req_ready", 128'(req_ready), 128'(0));
         q.delete();
         mdl_ptr   = 0;
         hold_prev = 1'b0;
      end else begin
         exp_rv = 1'b0;
         if (q.size() > 0) exp_rv = (q[0].acc + 2 <= cyc);
         chk("resp_valid", 128'(resp_valid), 128'(exp_rv));
         if (hold_prev)
            chk("resp_hold", 128'({resp_data, resp_exc, resp_tag, resp_src}), 128'(hold_val));
         free = (q.size() < 2) || resp_ready;
         if (resp_valid && resp_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("resp_data", 128'(resp_data), 128'(e.data));
            chk("resp_exc", 128'(resp_exc), 128'(e.exc));
            chk("resp_tag", 128'(resp_tag), 128'(e.tag));
            chk("resp_src", 128'(resp_src), 128'(e.src));
         end
         gi = mdl_ptr;
         for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(mdl_ptr + k) % NREQ]) gi = (mdl_ptr + k) % NREQ;
         exp_ready = '0;
         if (!flush && free) exp_ready[gi] = 1'b1;
         chk("req_ready", 128'(req_ready), 128'(exp_ready));
         if (flush) begin
            q.delete();
         end else if (req_valid[gi] && exp_ready[gi]) begin
            rm_eff = req_rm[gi*3 +: 3];
            if (rm_eff == 3'b111) rm_eff = frm;
            r = conv_ref(req_signed[gi], req_data[gi*64 +: 64], rm_eff);
            q.push_back('{data: r[64:0], exc: r[69:65], tag: req_tag[gi*TAG_W +: TAG_W],
                          src: 1'(gi), acc: cyc});
            acc_log.push_back(gi);
            mdl_ptr = (gi + 1) % NREQ;
         end
         hold_prev = resp_valid && !resp_ready && !flush;
         hold_val  = {resp_data, resp_exc, resp_tag, resp_src};
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic s, input logic [63:0] d,
                          input logic [2:0] rm, input logic [TAG_W-1:0] tag);
      req_signed[i]            = s;
      req_data[i*64 +: 64]     = d;
      req_rm[i*3 +: 3]         = rm;
      req_tag[i*TAG_W +: TAG_W] = tag;
      req_valid[i]             = 1'b1;
   endtask

   task automatic drain();
      req_valid  = '0;
      flush      = 1'b0;
      resp_ready = 1'b1;
      repeat (5) tick();
      chk("drained", 128'(q.size()), 128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_before;
      resp_ready = 1'b1;
      tick();
      tick();
      @(negedge clock);
      chk("rst_resp_valid", 128'(resp_valid), 128'(0));
      chk("rst_resp_data", 128'(resp_data), 128'(0));
      chk("rst_resp_exc", 128'(resp_exc), 128'(0));
      chk("rst_resp_tag", 128'(resp_tag), 128'(0));
      chk("rst_resp_src", 128'(resp_src), 128'(0));
      chk("rst_conv", 128'({conv_signedIn, conv_in, conv_roundingMode}), 128'(0));
      tick();
      reset = 1'b1;

      // -1 signed, RNE: exact -1.0
      set_req(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 8'h11);
      tick();
      req_valid = '0;
      tick();
      @(negedge clock);
      chk("t1_valid", 128'(resp_valid), 128'(1));
      chk("t1_data", 128'(resp_data), 128'(65'h1_8000_0000_0000_0000));
      chk("t1_exc", 128'(resp_exc), 128'(0));
      chk("t1_src", 128'(resp_src), 128'(0));

      // rm=7 resolves to frm at accept; frm changes afterwards
      frm = 3'd0;
      set_req(1, 1'b0, 64'h0020_0000_0000_0001, 3'd7, 8'h22);
      tick();
      req_valid = '0;
      frm = 3'd3;
      @(negedge clock);
      chk("t2_conv_rm", 128'(conv_roundingMode), 128'(0));
      chk("t2_conv_in", 128'(conv_in), 128'(64'h0020_0000_0000_0001));
      tick();
      @(negedge clock);
      chk("t2_exc", 128'(resp_exc), 128'(5'h01));
      chk("t2_src", 128'(resp_src), 128'(1));
      chk("t2_tag", 128'(resp_tag), 128'(8'h22));
      drain();

      // Alternating grants at full throughput
      acc_log.delete();
      for (int k = 0; k < 6; k++) begin
         set_req(0, 1'b1, 64'(k * 1000 + 7), 3'(k % 5), 8'(8'h30 + k));
         set_req(1, 1'b0, 64'(k) << 40, 3'd7, 8'(8'h40 + k));
         tick();
      end
      drain();
      chk("t3_count", 128'(acc_log.size()), 128'(6));
      for (int k = 0; k < 6 && k < acc_log.size(); k++)
         chk("t3_grant", 128'(acc_log[k]), 128'(k % 2));

      // Backpressure: two accepts fill S1/S2, then nothing
      acc_log.delete();
      resp_ready = 1'b0;
      set_req(0, 1'b0, 64'h1234_5678_9ABC_DEF1, 3'd2, 8'h50);
      set_req(1, 1'b1, 64'h8000_0000_0000_0003, 3'd4, 8'h51);
      repeat (5) tick();
      chk("t4_accepts", 128'(acc_log.size()), 128'(2));
      drain();

      // Flush with S1 and S2 full; rr_ptr left at 1 must survive it
      acc_log.delete();
      resp_ready = 1'b0;
      set_req(0, 1'b0, 64'd99, 3'd0, 8'h60);
      tick();
      set_req(0, 1'b0, 64'd98, 3'd0, 8'h61);
      tick();
      set_req(1, 1'b0, 64'd97, 3'd0, 8'h62);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clock);
      chk("t5_resp_valid", 128'(resp_valid), 128'(0));
      resp_ready = 1'b1;
      tick();
      req_valid = '0;
      n_before = acc_log.size();
      chk("t5_accepts", 128'(n_before), 128'(3));
      if (n_before == 3) chk("t5_grant_after_flush", 128'(acc_log[2]), 128'(1));
      drain();

      // Reset mid-stream, leaving rr_ptr at 1 beforehand
      set_req(0, 1'b1, 64'hFFFF_FFFF_0000_0001, 3'd1, 8'h70);
      set_req(1, 1'b0, 64'h0000_0001_0000_0001, 3'd3, 8'h71);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      acc_log.delete();
      @(negedge clock);
      chk("t6_resp_valid", 128'(resp_valid), 128'(0));
      tick();
      chk("t6_accepts", 128'(acc_log.size()), 128'(1));
      if (acc_log.size() > 0) chk("t6_first_grant", 128'(acc_log[0]), 128'(0));
      drain();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 3) != 0) begin
               set_req(i, 1'($urandom_range(0, 1)), {$urandom, $urandom} >> $urandom_range(0, 63),
                       3'($urandom_range(0, 7)), tagc);
               tagc = tagc + 8'd1;
            end else begin
               req_valid[i] = 1'b0;
            end
         end
         frm        = 3'($urandom_range(0, 6));
         resp_ready = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 49) == 0);
         reset      = ($urandom_range(0, 99) != 0);
         tick();
      end
      reset = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
